input_cond: RTL and testbench
=============================

INPUT_COND -- requirements
Module: input_cond

Interface
REQ-001 Parameter DIV, default 50_000_000: clk cycles per Pulse tick; legal range 2 and up.
REQ-002 Parameter DB, default 16: debounce length in clk cycles; legal range 1 and up.
REQ-003 Parameter RPT_DLY, default 2: Pulse ticks a held advance button waits before auto-repeat starts; legal range 1 and up.
REQ-004 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port btn_raw  input  5  asynchronous raw buttons; bit 0 Timeset, bit 1 Alarmset, bit 2 Minadv, bit 3 Hrsadv, bit 4 Alarmon.
REQ-007 Port Pulse  output  1  one-clk-wide tick, once every DIV cycles.
REQ-008 Port btn_lvl  output  5  debounced button levels, same bit order as btn_raw.
REQ-009 Port Minadv_stb  output  1  one-clk minute-advance strobe.
REQ-010 Port Hrsadv_stb  output  1  one-clk hour-advance strobe.

Function
REQ-011 Each btn_raw bit passes a 2-flop synchronizer; there is no combinational path from btn_raw to any output.
REQ-012 Tick divider counts 0..DIV-1 and wraps to 0; Pulse is high exactly in the cycle where the count equals DIV-1.
REQ-013 Divider width is $clog2(DIV) bits; the count never reaches DIV.
REQ-014 Per-bit debounce counter: it increments while the synchronized value differs from btn_lvl and clears to 0 when they agree.
REQ-015 When the debounce counter reaches DB, btn_lvl toggles and the counter clears in the same edge.
REQ-016 Latency: raw change held stable appears on btn_lvl exactly 2+DB clk edges after it is first sampled.
REQ-017 A glitch shorter than DB cycles after synchronization leaves btn_lvl unchanged.
REQ-018 Each advance channel (Minadv, Hrsadv) has an independent FSM with states IDLE, DELAY, REPEAT.
REQ-019 IDLE to DELAY on a btn_lvl rising edge; the strobe is asserted for that one cycle and the tick counter clears.
REQ-020 In DELAY, each Pulse increments the tick counter; when the RPT_DLY-th tick arrives, the FSM enters REPEAT and strobes in that cycle.
REQ-021 In REPEAT, the strobe is asserted in every cycle where Pulse is high.
REQ-022 A btn_lvl low forces IDLE from any state in the next edge, with no strobe in that cycle.
REQ-023 A press edge coinciding with Pulse produces exactly one strobe and does not count as a DELAY tick.
REQ-024 Minadv and Hrsadv strobe independently; simultaneous strobes are legal.
REQ-025 Strobes are gated off while btn_lvl[0] and btn_lvl[1] are both high, or both low; FSMs still track state in that condition.

Reset
REQ-026 On rst high at a clk edge, the following clear to 0: divider, synchronizers, debounce counters, btn_lvl, Pulse, both strobes and tick counters; both FSMs go to IDLE.
REQ-027 rst takes priority over every other event, including mid-debounce and mid-REPEAT.
REQ-028 The first Pulse after reset occurs DIV cycles after the first edge with rst low.

Configuration
REQ-029 Macro INPUT_COND_AUTOREPEAT_EN defined: the behaviour in REQ-018..REQ-024 applies.
REQ-030 Macro INPUT_COND_AUTOREPEAT_EN undefined: the DELAY and REPEAT states and tick counters are absent, and each press edge gives exactly one strobe.
REQ-031 Macro INPUT_COND_AUTOREPEAT_EN undefined: RPT_DLY is ignored.

Verification (DIV=10, DB=4, RPT_DLY=3)
REQ-032 Release rst -> Pulse high at cycles 10, 20, 30 after release, low elsewhere.
REQ-033 Raw Alarmon high, stable -> btn_lvl[4] rises 6 edges after first sample; a 3-cycle raw glitch -> btn_lvl[4] stays 0.
REQ-034 Timeset held, Minadv held 60 cycles (macro defined) -> 1 strobe on press, next at the 3rd Pulse after press, then 1 per Pulse until release.
REQ-035 Same stimulus with macro undefined -> exactly 1 Minadv_stb.
REQ-036 Timeset and Alarmset both held, then Hrsadv pressed -> Hrsadv_stb stays 0.
REQ-037 rst asserted mid-REPEAT -> next edge: all outputs 0, FSM IDLE, and the next Pulse comes 10 cycles after rst falls.

Source files
------------

// File: rtl/input_cond_if.sv
// input_cond_if -- button/strobe bundle between the input conditioner and
// its consumer. The conditioner side uses the slave modport, the consumer
// (clock core or testbench) uses the master modport.
//
// Handshake semantics: there is no valid/ready pair here. btn_raw is a free
// running asynchronous level; Pulse, Minadv_stb and Hrsadv_stb are single
// cycle qualifiers that are meaningful only in the cycle they are high and
// are never back-pressured. btn_lvl, min_state and hrs_state are plain levels.
interface input_cond_if;
    logic [4:0] btn_raw;     // raw buttons: 0 Timeset, 1 Alarmset, 2 Minadv, 3 Hrsadv, 4 Alarmon
    logic       Pulse;       // one-clk tick every DIV cycles
    logic [4:0] btn_lvl;     // debounced levels, same bit order as btn_raw
    logic       Minadv_stb;  // one-clk minute-advance strobe
    logic       Hrsadv_stb;  // one-clk hour-advance strobe
    logic [1:0] min_state;   // debug: minute-advance FSM state
    logic [1:0] hrs_state;   // debug: hour-advance FSM state

    modport master (
        output btn_raw,
        input  Pulse, btn_lvl, Minadv_stb, Hrsadv_stb, min_state, hrs_state
    );

    modport slave (
        input  btn_raw,
        output Pulse, btn_lvl, Minadv_stb, Hrsadv_stb, min_state, hrs_state
    );
endinterface

// File: rtl/input_cond.sv
// input_cond -- button conditioner for the alarm clock.
// Synchronizes and debounces five raw buttons, generates the Pulse tick and
// turns the Minadv/Hrsadv buttons into advance strobes.
// Optional feature macro: INPUT_COND_AUTOREPEAT_EN
//   defined   -> held advance buttons auto-repeat (IDLE/DELAY/REPEAT FSMs)
//   undefined -> one strobe per press, RPT_DLY is ignored
// Strobes are registered: they appear in the cycle after the event
// (press edge or Pulse) that causes them.
module input_cond #(
    parameter int DIV     = 50_000_000,
    parameter int DB      = 16,
    parameter int RPT_DLY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input_cond_if.slave  bus
);
    localparam int CW  = $clog2(DIV);
    localparam int DBW = $clog2(DB + 1);

    // Reject parameter values outside their legal range at elaboration.
    if (DIV < 2 || DB < 1 || RPT_DLY < 1) begin : g_bad_params
        $error("input_cond: illegal parameter value");
    end

`ifdef INPUT_COND_AUTOREPEAT_EN
    localparam int TW = $clog2(RPT_DLY + 1);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DELAY = 2'd1, ST_REPEAT = 2'd2} adv_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HELD = 2'd3} adv_state_e;
`endif

    // ---------------- tick divider ----------------
    logic [CW-1:0] div_q, div_d;
    logic          pulse;

    // Next divider count: 0..DIV-1, wrapping before it can reach DIV.
    always_comb begin
        div_d = div_q + 1'b1;
        if (div_q == CW'(DIV - 1)) div_d = '0;
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    // Pulse is a decode of the registered count, so it is glitch-free and
    // has no path from the button inputs.
    assign pulse = (div_q == CW'(DIV - 1));

    // ---------------- synchronizer + debounce ----------------
    logic [4:0]     sync1_q, sync2_q, lvl_q;
    logic [DBW-1:0] db_q [5];

    // Two-flop synchronizer, then a per-bit counter that must see DB
    // consecutive disagreeing samples before the level flips.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            for (int i = 0; i < 5; i++) db_q[i] <= '0;
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] == lvl_q[i]) begin
                    db_q[i] <= '0;
                end else if (db_q[i] == DBW'(DB - 1)) begin
                    lvl_q[i] <= ~lvl_q[i];
                    db_q[i]  <= '0;
                end else begin
                    db_q[i] <= db_q[i] + 1'b1;
                end
            end
        end
    end

    // Advance strobes are only allowed while exactly one of Timeset and
    // Alarmset is held; the FSMs keep tracking the buttons regardless.
    logic       gate_ok;
    logic [1:0] adv_lvl;
    logic [1:0] adv_stb;
    logic [1:0] adv_state [2];

    assign gate_ok = lvl_q[0] ^ lvl_q[1];
    assign adv_lvl = lvl_q[3:2];

    // ---------------- advance channels (0 = Minadv, 1 = Hrsadv) ----------------
    for (genvar ch = 0; ch < 2; ch++) begin : g_adv
        adv_state_e state_q;
        logic       stb_q;
`ifdef INPUT_COND_AUTOREPEAT_EN
        logic [TW-1:0] tick_q;

        // Press strobes once, waits RPT_DLY ticks, then strobes on every tick.
        // A press landing on a Pulse cycle does not count as a delay tick.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                tick_q  <= '0;
                stb_q   <= 1'b0;
            end else if (!adv_lvl[ch]) begin
                state_q <= ST_IDLE;
                tick_q  <= '0;
                stb_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_DELAY;
                        tick_q  <= '0;
                        stb_q   <= gate_ok;
                    end
                    ST_DELAY: begin
                        stb_q <= 1'b0;
                        if (pulse) begin
                            if (tick_q == TW'(RPT_DLY - 1)) begin
                                state_q <= ST_REPEAT;
                                tick_q  <= '0;
                                stb_q   <= gate_ok;
                            end else begin
                                tick_q <= tick_q + 1'b1;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        stb_q <= pulse & gate_ok;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        tick_q  <= '0;
                        stb_q   <= 1'b0;
                    end
                endcase
            end
        end
`else
        // One strobe per press edge; HELD waits for the release.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                stb_q   <= 1'b0;
            end else if (!adv_lvl[ch]) begin
                state_q <= ST_IDLE;
                stb_q   <= 1'b0;
            end else if (state_q == ST_IDLE) begin
                state_q <= ST_HELD;
                stb_q   <= gate_ok;
            end else begin
                stb_q <= 1'b0;
            end
        end
`endif
        assign adv_stb[ch]   = stb_q;
        assign adv_state[ch] = state_q;
    end

    assign bus.Pulse      = pulse;
    assign bus.btn_lvl    = lvl_q;
    assign bus.Minadv_stb = adv_stb[0];
    assign bus.Hrsadv_stb = adv_stb[1];
    assign bus.min_state  = adv_state[0];
    assign bus.hrs_state  = adv_state[1];
endmodule

// File: tb/tb_input_cond.sv
// tb_input_cond -- directed bench for input_cond with DIV=10, DB=4, RPT_DLY=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// ph holds the divider phase expected after the latest edge (0 on a reset edge),
// so Pulse is expected high exactly when ph == 9.
module tb_input_cond;
`ifdef INPUT_COND_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    input_cond_if bus ();

    input_cond #(.DIV(10), .DB(4), .RPT_DLY(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_asserts;
    int n_fail;
    int ph;
    int cnt;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // One clock edge, then check Pulse against the tracked divider phase.
    task automatic step();
        @(posedge clk);
        if (rst) ph = 0;
        else     ph = (ph + 1) % 10;
        #1;
        chk("pulse", 32'(bus.Pulse), 32'(ph == 9));
    endtask

    // Advance until the divider phase equals p (at most one period).
    task automatic align(input int p);
        for (int g = 0; g < 10 && ph != p; g++) step();
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        ph        = 0;
        rst       = 1'b1;
        bus.btn_raw = '0;

        // Reset state
        repeat (3) step();
        chk("rst_lvl", 32'(bus.btn_lvl), 32'h0);
        chk("rst_min_stb", 32'(bus.Minadv_stb), 32'h0);
        chk("rst_hrs_stb", 32'(bus.Hrsadv_stb), 32'h0);
        chk("rst_min_state", 32'(bus.min_state), 32'h0);
        chk("rst_hrs_state", 32'(bus.hrs_state), 32'h0);

        // Pulse at cycles 10, 20, 30 after release (edges 9, 19, 29)
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            chk("pulse_cycle", 32'(bus.Pulse), 32'((k % 10) == 9));
        end

        // Alarmon debounce: rises 6 edges after first sample
        bus.btn_raw[4] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("lvl4_rise", 32'(bus.btn_lvl[4]), 32'(k == 6));
        end
        bus.btn_raw[4] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("lvl4_fall", 32'(bus.btn_lvl[4]), 32'(k < 6));
        end

        // 3-cycle glitch is filtered
        bus.btn_raw[4] = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 3) bus.btn_raw[4] = 1'b0;
            chk("lvl4_glitch", 32'(bus.btn_lvl[4]), 32'h0);
        end

        // Timeset held, Minadv held 60 cycles. Press starts at phase 3, so the
        // debounced edge meets a Pulse (no delay tick); strobes at press+7,
        // then (auto-repeat) at +37 (3rd tick), +47, +57; release at +67 gives none.
        bus.btn_raw[0] = 1'b1;
        repeat (8) step();
        chk("timeset_lvl", 32'(bus.btn_lvl), 32'h01);
        align(3);
        bus.btn_raw[2] = 1'b1;
        cnt = 0;
        for (int j = 1; j <= 75; j++) begin
            step();
            chk("minadv_stb", 32'(bus.Minadv_stb),
                32'((j == 7) || (AUTO && (j == 37 || j == 47 || j == 57))));
            chk("hrsadv_idle", 32'(bus.Hrsadv_stb), 32'h0);
            cnt += int'(bus.Minadv_stb);
            if (j == 60) bus.btn_raw[2] = 1'b0;
        end
        chk("minadv_count", 32'(cnt), AUTO ? 32'd4 : 32'd1);
        chk("min_state_released", 32'(bus.min_state), 32'h0);

        // Simultaneous Minadv and Hrsadv presses strobe together
        align(3);
        bus.btn_raw[3:2] = 2'b11;
        for (int j = 1; j <= 10; j++) begin
            step();
            chk("both_min", 32'(bus.Minadv_stb), 32'(j == 7));
            chk("both_hrs", 32'(bus.Hrsadv_stb), 32'(j == 7));
        end
        bus.btn_raw[3:2] = 2'b00;
        repeat (8) step();
        chk("both_released", 32'(bus.btn_lvl), 32'h01);

        // Timeset and Alarmset both held: Hrsadv strobes gated, FSM still tracks
        bus.btn_raw[1] = 1'b1;
        repeat (8) step();
        chk("gate_lvl", 32'(bus.btn_lvl), 32'h03);
        bus.btn_raw[3] = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            step();
            chk("hrs_gated", 32'(bus.Hrsadv_stb), 32'h0);
        end
        chk("hrs_state_tracks", 32'(bus.hrs_state), AUTO ? 32'd2 : 32'd3);
        bus.btn_raw[3] = 1'b0;
        bus.btn_raw[1] = 1'b0;
        repeat (8) step();
        chk("gate_released", 32'(bus.btn_lvl), 32'h01);

        // Reset in the middle of REPEAT
        align(3);
        bus.btn_raw[2] = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            step();
            chk("pre_rst_stb", 32'(bus.Minadv_stb), 32'((j == 7) || (AUTO && j == 37)));
        end
        chk("pre_rst_state", 32'(bus.min_state), AUTO ? 32'd2 : 32'd3);
        rst = 1'b1;
        bus.btn_raw = '0;
        step();
        chk("mid_rst_pulse", 32'(bus.Pulse), 32'h0);
        chk("mid_rst_lvl", 32'(bus.btn_lvl), 32'h0);
        chk("mid_rst_min_stb", 32'(bus.Minadv_stb), 32'h0);
        chk("mid_rst_hrs_stb", 32'(bus.Hrsadv_stb), 32'h0);
        chk("mid_rst_state", 32'(bus.min_state), 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("post_rst_pulse", 32'(bus.Pulse), 32'(k == 9));
            chk("post_rst_stb", 32'(bus.Minadv_stb), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
